// File: rtl/alu_seq_nbit.sv
// alu_seq_nbit: registered N-bit ALU with a persistent {V,C,N,Z} status
// register, carry-chained ADC/SBC, and a WIDTH-cycle shift-add multiplier
// behind a valid/ready handshake.
module alu_seq_nbit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUOp,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic [3:0]       sreg
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_ADC = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SUB = 3'b110,
        OP_SBC = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         sreg_q, sreg_d;
    logic               out_valid_q, out_valid_d;

    // Single-cycle datapath: operand conditioning, adder and logic ops.
    logic             sub_op;
    logic             cin;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [2*WIDTH-1:0] acc_step;

    // Combinational ALU result and flags for the non-multiply operations.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        sub_op  = ALUOp[2] & ALUOp[1];
        b_x     = sub_op ? ~b : b;
        // ADC/SBC chain the stored carry; SUB injects the +1 of two's complement.
        cin     = (ALUOp[1] & ALUOp[0]) ? sreg_q[2] : sub_op;
        sum_w   = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e'(ALUOp))
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[WIDTH-1] == b_x[WIDTH-1]) & (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Next-state and datapath-register update for the IDLE/MUL controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        result_d    = result_q;
        sreg_d      = sreg_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op_e'(ALUOp) == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        result_d    = alu_res;
                        sreg_d      = {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Last step: commit the low half; C flags a truncated product.
                    result_d    = acc_step[WIDTH-1:0];
                    sreg_d      = {1'b0, (acc_step[2*WIDTH-1:WIDTH] != '0),
                                   acc_step[WIDTH-1], (acc_step[WIDTH-1:0] == '0)};
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: multiplier working registers are reset too, so an aborted MUL leaves nothing stale.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            sreg_q      <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            sreg_q      <= sreg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign result    = result_q;
    assign sreg      = sreg_q;
    assign out_valid = out_valid_q;

endmodule
